// File: rtl/enemy_formation.sv
// Invader formation: a ROWS_P x COLS_P grid that marches as one rigid block,
// drops and reverses at the screen edges, speeds up as ships die, and
// reports its live bounding box and landed/cleared status.
module enemy_formation #(
  parameter int          ROWS_P        = 3,
  parameter int          COLS_P        = 8,
  parameter logic [9:0]  SHIP_W_P      = 10'd30,
  parameter logic [9:0]  SHIP_H_P      = 10'd16,
  parameter logic [9:0]  COL_PITCH_P   = 10'd45,
  parameter logic [9:0]  ROW_PITCH_P   = 10'd30,
  parameter logic [9:0]  START_X_P     = 10'd40,
  parameter logic [9:0]  START_Y_P     = 10'd40,
  parameter logic [9:0]  LEFT_BOUND_P  = 10'd10,
  parameter logic [9:0]  RIGHT_BOUND_P = 10'd629,
  parameter logic [9:0]  LAND_Y_P      = 10'd440,
  parameter logic [9:0]  STEP_P        = 10'd10,
  parameter logic [9:0]  DROP_P        = 10'd10,
  parameter int          FRAMES_P      = 30,
  parameter int          FAST_FRAMES_P = 8,
  parameter int          FAST_ALIVE_P  = 4,
  parameter logic [11:0] color_p       = 12'hFFF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_i,
  input  logic                     start_i,
  input  logic                     hit_valid_i,
  input  logic [2:0]               hit_row_i,
  input  logic [3:0]               hit_col_i,
  output logic                     hit_ack_o,
  output logic [ROWS_P*COLS_P-1:0] alive_o,
  output logic [7:0]               alive_count_o,
  output logic [9:0]               origin_x_o,
  output logic [9:0]               origin_y_o,
  output logic [9:0]               box_left_o,
  output logic [9:0]               box_right_o,
  output logic [9:0]               box_bot_o,
  output logic                     moving_right_o,
  output logic                     landed_o,
  output logic                     cleared_o,
  output logic [3:0]               enemy_red_o,
  output logic [3:0]               enemy_green_o,
  output logic [3:0]               enemy_blue_o
);

  localparam int N     = ROWS_P * COLS_P;
  localparam int MAXF  = (FRAMES_P > FAST_FRAMES_P) ? FRAMES_P : FAST_FRAMES_P;
  localparam int CNT_W = $clog2(MAXF + 1);

  typedef enum logic [2:0] {S_IDLE, S_RIGHT, S_LEFT, S_LANDED, S_CLEARED} state_t;

  typedef struct packed {
    logic [9:0] left;
    logic [9:0] right;
    logic [9:0] bot;
  } box_t;

  state_t             state_q, state_d;
  logic [9:0]         ox_q, oy_q, ox_d, oy_d;
  logic [N-1:0]       alive_q, alive_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period;
  logic               ack_q, ack_d, mr_q;
  logic               marching, terminal, reload, tick, drop, hit_ok;
  int                 hit_idx;
  box_t               box_cur, box_nxt;

  // Live bounding box of a given alive mask placed at a given origin; all
  // zero when nothing is alive.
  function automatic box_t calc_box(input logic [N-1:0] a,
                                    input logic [9:0] ox, input logic [9:0] oy);
    box_t b;
    int   cmin, cmax, rmax;
    logic any;
    cmin = COLS_P - 1;
    cmax = 0;
    rmax = 0;
    any  = 1'b0;
    for (int r = 0; r < ROWS_P; r++) begin
      for (int c = 0; c < COLS_P; c++) begin
        if (a[r*COLS_P+c]) begin
          any = 1'b1;
          if (c < cmin) cmin = c;
          if (c > cmax) cmax = c;
          if (r > rmax) rmax = r;
        end
      end
    end
    if (any) begin
      b.left  = ox + 10'(cmin) * COL_PITCH_P;
      b.right = ox + 10'(cmax) * COL_PITCH_P + SHIP_W_P - 10'd1;
      b.bot   = oy + 10'(rmax) * ROW_PITCH_P + SHIP_H_P - 10'd1;
    end else begin
      b = '0;
    end
    return b;
  endfunction

  // Population count of the alive mask.
  always_comb begin
    alive_count_o = '0;
    for (int i = 0; i < N; i++) alive_count_o = alive_count_o + 8'(alive_q[i]);
  end

  assign marching = (state_q == S_RIGHT) || (state_q == S_LEFT);
  assign terminal = (state_q == S_LANDED) || (state_q == S_CLEARED);
  assign reload   = terminal && start_i;
  assign period   = (alive_count_o <= 8'(FAST_ALIVE_P)) ? CNT_W'(FAST_FRAMES_P)
                                                         : CNT_W'(FRAMES_P);
  // ">=" so a freshly shortened period fires on the next frame.
  assign tick     = marching && frame_i && (cnt_q >= period - CNT_W'(1));
  assign box_cur  = calc_box(alive_q, ox_q, oy_q);
  // Edge decision is made on the pre-hit box.
  assign drop     = tick && (((state_q == S_RIGHT) && (box_cur.right + STEP_P > RIGHT_BOUND_P)) ||
                             ((state_q == S_LEFT)  && (box_cur.left < LEFT_BOUND_P + STEP_P)));
  assign hit_idx  = int'(hit_row_i) * COLS_P + int'(hit_col_i);
  assign hit_ok   = hit_valid_i && (state_q != S_IDLE) && !reload &&
                    (int'(hit_row_i) < ROWS_P) && (int'(hit_col_i) < COLS_P) &&
                    alive_q[hit_idx];

  // Next origin, alive mask, frame counter and hit acknowledge.
  always_comb begin
    ox_d    = ox_q;
    oy_d    = oy_q;
    alive_d = alive_q;
    cnt_d   = cnt_q;
    ack_d   = hit_ok;
    if (reload) begin
      ox_d    = START_X_P;
      oy_d    = START_Y_P;
      alive_d = '1;
      cnt_d   = '0;
    end else begin
      if (marching && frame_i) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (drop)                         oy_d = oy_q + DROP_P;
      else if (tick && state_q == S_RIGHT) ox_d = ox_q + STEP_P;
      else if (tick && state_q == S_LEFT)  ox_d = ox_q - STEP_P;
      if (hit_ok) alive_d[hit_idx] = 1'b0;
    end
  end

  assign box_nxt = calc_box(alive_d, ox_d, oy_d);

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ox_q    <= START_X_P;
      oy_q    <= START_Y_P;
      alive_q <= '1;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      mr_q    <= 1'b1;
    end else begin
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      alive_q <= alive_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      mr_q    <= moving_right_o;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state: marching direction, then cleared/landed on the updated view.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RIGHT;
      S_RIGHT, S_LEFT: begin
        if (drop) state_d = (state_q == S_RIGHT) ? S_LEFT : S_RIGHT;
        if (alive_d == '0)                state_d = S_CLEARED;
        else if (box_nxt.bot >= LAND_Y_P) state_d = S_LANDED;
      end
      S_LANDED, S_CLEARED: if (start_i) state_d = S_RIGHT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; direction holds through terminal states.
  always_comb begin
    landed_o  = (state_q == S_LANDED);
    cleared_o = (state_q == S_CLEARED);
    case (state_q)
      S_IDLE, S_RIGHT: moving_right_o = 1'b1;
      S_LEFT:          moving_right_o = 1'b0;
      default:         moving_right_o = mr_q;
    endcase
  end

  assign hit_ack_o     = ack_q;
  assign alive_o       = alive_q;
  assign origin_x_o    = ox_q;
  assign origin_y_o    = oy_q;
  assign box_left_o    = box_cur.left;
  assign box_right_o   = box_cur.right;
  assign box_bot_o     = box_cur.bot;
  assign enemy_red_o   = color_p[11:8];
  assign enemy_green_o = color_p[7:4];
  assign enemy_blue_o  = color_p[3:0];

endmodule
